// File: rtl/bg_tile_fetcher_if.sv
`default_nettype none
// ============================================================================
// bg_tile_fetcher_if : VRAM read path and pixel-FIFO push path of the fetcher
// Rev 1.0
// ============================================================================
interface bg_tile_fetcher_if;
  logic [12:0] ma_out;
  logic        vram_rd;
  logic [7:0]  md_in;
  logic        push;
  logic [7:0]  pix_lo;
  logic [7:0]  pix_hi;
  logic        fifo_ready;

  modport master (
    output ma_out, vram_rd, push, pix_lo, pix_hi,
    input  md_in, fifo_ready
  );

  modport slave (
    input  ma_out, vram_rd, push, pix_lo, pix_hi,
    output md_in, fifo_ready
  );
endinterface
`default_nettype wire

// File: rtl/bg_tile_fetcher.sv
`default_nettype none
// ============================================================================
// bg_tile_fetcher : PPU background/window tile fetch sequencer (map/lo/hi)
// Rev 1.0
// ============================================================================
module bg_tile_fetcher #(
  parameter logic [1:0] MAP_BASE_HI = 2'b11
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         frame_start,
  input  wire logic         start,
  input  wire logic         win_start,
  input  wire logic         line_end,
  input  wire logic         bg_map_sel,
  input  wire logic         win_map_sel,
  input  wire logic         tile_data_sel,
  input  wire logic [7:0]   scx,
  input  wire logic [7:0]   scy,
  input  wire logic [7:0]   ly,
  bg_tile_fetcher_if.master bus,
  output logic              busy,
  output logic              win_active
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAP0 = 3'd1,
    S_MAP1 = 3'd2,
    S_LO0  = 3'd3,
    S_LO1  = 3'd4,
    S_HI0  = 3'd5,
    S_HI1  = 3'd6,
    S_PUSH = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  tile_x_q, tile_x_d;
  logic [7:0]  tile_idx_q, tile_idx_d;
  logic [7:0]  lo_buf_q, lo_buf_d;
  logic [7:0]  pix_lo_q, pix_lo_d;
  logic [7:0]  pix_hi_q, pix_hi_d;
  logic [7:0]  wly_q, wly_d;
  logic [12:0] ma_q, ma_d;
  logic        vram_rd_q, vram_rd_d;
  logic        busy_q, busy_d;
  logic        win_active_q, win_active_d;

  logic [7:0]  bg_y;
  logic [2:0]  fine_y;
  logic [4:0]  map_row;
  logic [4:0]  map_col;
  logic        map_sel;
  logic [12:0] map_addr;
  logic [12:0] data_addr;

  // Sub-tile horizontal scroll is applied downstream by the pixel pipeline.
  logic scx_fine_unused;
  assign scx_fine_unused = ^scx[2:0];

  // Address generation: registers are sampled live in the first cycle of each
  // access and the result is held for the second cycle and while idle/pushing.
  always_comb begin
    bg_y      = ly + scy;
    fine_y    = win_active_q ? wly_q[2:0] : bg_y[2:0];
    map_row   = win_active_q ? wly_q[7:3] : bg_y[7:3];
    map_col   = win_active_q ? tile_x_q : (scx[7:3] + tile_x_q);
    map_sel   = win_active_q ? win_map_sel : bg_map_sel;
    map_addr  = {MAP_BASE_HI, map_sel, map_row, map_col};
    data_addr = {~(tile_data_sel | tile_idx_q[7]), tile_idx_q, fine_y, 1'b0};
    case (state_q)
      S_MAP0:  ma_d = map_addr;
      S_LO0:   ma_d = data_addr;
      S_HI0:   ma_d = data_addr | 13'd1;
      default: ma_d = ma_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    tile_x_d     = tile_x_q;
    tile_idx_d   = tile_idx_q;
    lo_buf_d     = lo_buf_q;
    pix_lo_d     = pix_lo_q;
    pix_hi_d     = pix_hi_q;
    wly_d        = wly_q;
    win_active_d = win_active_q;

    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_MAP0: state_d = S_MAP1;
      S_MAP1: begin
        state_d    = S_LO0;
        tile_idx_d = bus.md_in;
      end
      S_LO0:  state_d = S_LO1;
      S_LO1: begin
        state_d  = S_HI0;
        lo_buf_d = bus.md_in;
      end
      S_HI0:  state_d = S_HI1;
      // High plane goes straight to the output register; no separate buffer.
      S_HI1: begin
        state_d  = S_PUSH;
        pix_lo_d = lo_buf_q;
        pix_hi_d = bus.md_in;
      end
      S_PUSH: begin
        if (bus.fifo_ready) begin
          state_d  = S_MAP0;
          tile_x_d = tile_x_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (line_end) begin
      state_d      = S_IDLE;
      tile_x_d     = 5'd0;
      win_active_d = 1'b0;
      if (win_active_q) begin
        wly_d = wly_q + 8'd1;
      end
    end else if (win_start && !win_active_q) begin
      state_d      = S_MAP0;
      tile_x_d     = 5'd0;
      win_active_d = 1'b1;
    end else if (start) begin
      state_d  = S_MAP0;
      tile_x_d = 5'd0;
    end

    if (frame_start) begin
      wly_d = 8'd0;
    end

    vram_rd_d = (state_d != S_IDLE) && (state_d != S_PUSH);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tile_x_q     <= 5'd0;
      tile_idx_q   <= 8'd0;
      lo_buf_q     <= 8'd0;
      pix_lo_q     <= 8'd0;
      pix_hi_q     <= 8'd0;
      wly_q        <= 8'd0;
      ma_q         <= 13'd0;
      vram_rd_q    <= 1'b0;
      busy_q       <= 1'b0;
      win_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tile_x_q     <= tile_x_d;
      tile_idx_q   <= tile_idx_d;
      lo_buf_q     <= lo_buf_d;
      pix_lo_q     <= pix_lo_d;
      pix_hi_q     <= pix_hi_d;
      wly_q        <= wly_d;
      ma_q         <= ma_d;
      vram_rd_q    <= vram_rd_d;
      busy_q       <= busy_d;
      win_active_q <= win_active_d;
    end
  end

  assign bus.ma_out  = ma_d;
  assign bus.vram_rd = vram_rd_q;
  assign bus.push    = (state_q == S_PUSH) && bus.fifo_ready;
  assign bus.pix_lo  = pix_lo_q;
  assign bus.pix_hi  = pix_hi_q;
  assign busy        = busy_q;
  assign win_active  = win_active_q;

endmodule
`default_nettype wire

// File: tb/tb_bg_tile_fetcher.sv
`default_nettype none
// ============================================================================
// tb_bg_tile_fetcher : self-checking bench for bg_tile_fetcher
// Rev 1.0
// ============================================================================
module tb_bg_tile_fetcher;
  logic       clk = 1'b0;
  logic       reset, frame_start, start, win_start, line_end;
  logic       bg_map_sel, win_map_sel, tile_data_sel;
  logic [7:0] scx, scy, ly;
  logic       busy, win_active;

  int n_tests = 0;
  int n_fail  = 0;
  int push_cnt = 0;
  logic [15:0] push_log[$];

  logic [7:0]  vram [0:8191];
  logic [12:0] obs_ma   [1:16];
  logic        obs_rd   [1:16];
  logic        obs_push [1:16];
  logic [7:0]  obs_lo   [1:16];
  logic [7:0]  obs_hi   [1:16];

  bg_tile_fetcher_if bus();

  bg_tile_fetcher #(.MAP_BASE_HI(2'b11)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .start(start),
    .win_start(win_start), .line_end(line_end), .bg_map_sel(bg_map_sel),
    .win_map_sel(win_map_sel), .tile_data_sel(tile_data_sel),
    .scx(scx), .scy(scy), .ly(ly), .bus(bus), .busy(busy), .win_active(win_active)
  );

  always #5 clk = ~clk;

  // VRAM model answers whatever address the fetcher presents
  assign bus.md_in = vram[bus.ma_out];

  always @(negedge clk) begin
    if (bus.push === 1'b1) begin
      push_cnt++;
      push_log.push_back({bus.pix_hi, bus.pix_lo});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  // ---------------- reference model (address arithmetic) ----------------
  function automatic logic [12:0] bg_map(input int k);
    int y, col;
    y   = (int'(ly) + int'(scy)) % 256;
    col = (int'(scx) / 8 + k) % 32;
    return 13'((bg_map_sel ? 'h1C00 : 'h1800) + (y / 8) * 32 + col);
  endfunction

  function automatic int bg_fy();
    return (int'(ly) + int'(scy)) % 8;
  endfunction

  function automatic logic [12:0] win_map(input int wl, input int k);
    return 13'((win_map_sel ? 'h1C00 : 'h1800) + (wl / 8) * 32 + k);
  endfunction

  function automatic logic [12:0] exp_tile(input logic [7:0] idx, input logic tds,
                                           input int fy, input logic hi);
    int base;
    if (tds) base = int'(idx) * 16;
    else     base = 4096 + int'($signed(idx)) * 16;
    return 13'(base + fy * 2 + int'(hi));
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_line_end();
    line_end = 1'b1; tick(); line_end = 1'b0;
  endtask

  task automatic observe(input int n);
    for (int i = 1; i <= n; i++) begin
      #1;
      obs_ma[i]   = bus.ma_out;
      obs_rd[i]   = bus.vram_rd;
      obs_push[i] = bus.push;
      obs_lo[i]   = bus.pix_lo;
      obs_hi[i]   = bus.pix_hi;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    bus.fifo_ready = 1'b1;
    #1;
    n_tests++; if (bus.ma_out !== 13'h0) begin n_fail++; $display("FAIL reset_ma: got %h required 0000", bus.ma_out); end
    n_tests++; if (bus.vram_rd !== 1'b0) begin n_fail++; $display("FAIL reset_vram_rd: got %b required 0", bus.vram_rd); end
    n_tests++; if (bus.push !== 1'b0) begin n_fail++; $display("FAIL reset_push: got %b required 0", bus.push); end
    n_tests++; if ({bus.pix_hi, bus.pix_lo} !== 16'h0) begin n_fail++; $display("FAIL reset_pix: got %h%h required 0000", bus.pix_hi, bus.pix_lo); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_tests++; if (win_active !== 1'b0) begin n_fail++; $display("FAIL reset_win_active: got %b required 0", win_active); end
  endtask

  task automatic test_bg_sequence();
    logic [12:0] e_ma;
    scx = 8'h13; scy = 8'h05; ly = 8'h0A;
    bg_map_sel = 1'b0; tile_data_sel = 1'b0; bus.fifo_ready = 1'b1;
    vram[bg_map(0)] = 8'h80;
    vram[exp_tile(8'h80, 1'b0, bg_fy(), 1'b0)] = 8'h5A;
    vram[exp_tile(8'h80, 1'b0, bg_fy(), 1'b1)] = 8'hC3;
    start = 1'b1; tick(); start = 1'b0;
    observe(7);
    n_tests++; if (obs_ma[1] !== 13'h1822) begin n_fail++; $display("FAIL bg_map_const: got %h required 1822", obs_ma[1]); end
    n_tests++; if (obs_ma[3] !== 13'h080E) begin n_fail++; $display("FAIL bg_lo_const: got %h required 080e", obs_ma[3]); end
    for (int i = 1; i <= 7; i++) begin
      e_ma = (i <= 2) ? bg_map(0) : exp_tile(8'h80, 1'b0, bg_fy(), (i >= 5));
      n_tests++; if (obs_ma[i] !== e_ma) begin n_fail++; $display("FAIL bg_seq_ma c%0d: got %h required %h", i, obs_ma[i], e_ma); end
      n_tests++; if (obs_rd[i] !== (i <= 6)) begin n_fail++; $display("FAIL bg_seq_rd c%0d: got %b required %b", i, obs_rd[i], (i <= 6)); end
      n_tests++; if (obs_push[i] !== (i == 7)) begin n_fail++; $display("FAIL bg_seq_push c%0d: got %b required %b", i, obs_push[i], (i == 7)); end
    end
    n_tests++; if ({obs_hi[7], obs_lo[7]} !== 16'hC35A) begin n_fail++; $display("FAIL bg_seq_pix: got %h%h required c35a", obs_hi[7], obs_lo[7]); end
    pulse_line_end();
  endtask

  task automatic test_signed_push();
    vram[bg_map(0)] = 8'h05;
    vram[13'h105E] = 8'hA5;
    vram[13'h105F] = 8'h3C;
    bus.fifo_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    observe(8);
    n_tests++; if (obs_ma[3] !== exp_tile(8'h05, 1'b0, bg_fy(), 1'b0)) begin n_fail++; $display("FAIL signed_lo_addr: got %h required %h", obs_ma[3], exp_tile(8'h05, 1'b0, bg_fy(), 1'b0)); end
    n_tests++; if (obs_push[7] !== 1'b1) begin n_fail++; $display("FAIL signed_push: got %b required 1", obs_push[7]); end
    n_tests++; if ({obs_hi[7], obs_lo[7]} !== 16'h3CA5) begin n_fail++; $display("FAIL signed_pix: got %h%h required 3ca5", obs_hi[7], obs_lo[7]); end
    n_tests++; if (obs_ma[8] !== bg_map(1)) begin n_fail++; $display("FAIL next_map_addr: got %h required %h", obs_ma[8], bg_map(1)); end
    n_tests++; if (obs_ma[8] !== 13'h1823) begin n_fail++; $display("FAIL next_map_const: got %h required 1823", obs_ma[8]); end
    pulse_line_end();
  endtask

  task automatic test_backpressure();
    int c0;
    bus.fifo_ready = 1'b0;
    c0 = push_cnt;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++; if (bus.push !== 1'b0) begin n_fail++; $display("FAIL bp_push h%0d: got %b required 0", i, bus.push); end
      n_tests++; if (bus.vram_rd !== 1'b0) begin n_fail++; $display("FAIL bp_vram_rd h%0d: got %b required 0", i, bus.vram_rd); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy h%0d: got %b required 1", i, busy); end
      n_tests++; if (bus.ma_out !== 13'h105F) begin n_fail++; $display("FAIL bp_ma_hold h%0d: got %h required 105f", i, bus.ma_out); end
      tick();
    end
    bus.fifo_ready = 1'b1;
    #1;
    n_tests++; if (bus.push !== 1'b1) begin n_fail++; $display("FAIL bp_release_push: got %b required 1", bus.push); end
    n_tests++; if (bus.pix_lo !== 8'hA5) begin n_fail++; $display("FAIL bp_release_pix: got %h required a5", bus.pix_lo); end
    tick();
    bus.fifo_ready = 1'b0;
    #1;
    n_tests++; if (bus.ma_out !== bg_map(1)) begin n_fail++; $display("FAIL bp_next_map: got %h required %h", bus.ma_out, bg_map(1)); end
    pulse_line_end();
    n_tests++; if (push_cnt - c0 !== 1) begin n_fail++; $display("FAIL bp_push_count: got %0d required 1", push_cnt - c0); end
  endtask

  task automatic test_window();
    int c0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      win_start = 1'b1; tick(); win_start = 1'b0;
      pulse_line_end();
    end
    win_map_sel = 1'b1; tile_data_sel = 1'b1; bus.fifo_ready = 1'b1;
    vram[win_map(11, 0)] = 8'h21;
    vram[exp_tile(8'h21, 1'b1, 3, 1'b0)] = 8'h66;
    vram[exp_tile(8'h21, 1'b1, 3, 1'b1)] = 8'h99;
    c0 = push_cnt;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    win_start = 1'b1; tick(); win_start = 1'b0;
    #1;
    n_tests++; if (bus.ma_out !== 13'h1C20) begin n_fail++; $display("FAIL win_map_addr: got %h required 1c20", bus.ma_out); end
    n_tests++; if (win_active !== 1'b1) begin n_fail++; $display("FAIL win_active_set: got %b required 1", win_active); end
    observe(7);
    n_tests++; if (obs_ma[3] !== exp_tile(8'h21, 1'b1, 3, 1'b0)) begin n_fail++; $display("FAIL win_lo_addr: got %h required %h", obs_ma[3], exp_tile(8'h21, 1'b1, 3, 1'b0)); end
    n_tests++; if ({obs_push[7], obs_hi[7], obs_lo[7]} !== {1'b1, 16'h9966}) begin n_fail++; $display("FAIL win_push: got %b %h%h required 1 9966", obs_push[7], obs_hi[7], obs_lo[7]); end
    n_tests++; if (push_cnt - c0 !== 1) begin n_fail++; $display("FAIL win_discard: got %0d pushes required 1", push_cnt - c0); end
    pulse_line_end();
    #1;
    n_tests++; if ({busy, win_active} !== 2'b00) begin n_fail++; $display("FAIL win_line_end: got busy=%b win=%b required 0 0", busy, win_active); end
    // wly now 12: row unchanged, fine_y 4
    win_start = 1'b1; tick(); win_start = 1'b0;
    observe(3);
    n_tests++; if (obs_ma[3] !== exp_tile(8'h21, 1'b1, 4, 1'b0)) begin n_fail++; $display("FAIL wly_incr: got %h required %h", obs_ma[3], exp_tile(8'h21, 1'b1, 4, 1'b0)); end
    frame_start = 1'b1; line_end = 1'b1; tick(); frame_start = 1'b0; line_end = 1'b0;
    vram[win_map(0, 0)] = 8'h07;
    win_start = 1'b1; tick(); win_start = 1'b0;
    observe(3);
    n_tests++; if (obs_ma[1] !== win_map(0, 0)) begin n_fail++; $display("FAIL frame_start_map: got %h required %h", obs_ma[1], win_map(0, 0)); end
    n_tests++; if (obs_ma[3] !== exp_tile(8'h07, 1'b1, 0, 1'b0)) begin n_fail++; $display("FAIL frame_start_wins: got %h required %h", obs_ma[3], exp_tile(8'h07, 1'b1, 0, 1'b0)); end
    pulse_line_end();
  endtask

  task automatic test_col_wrap();
    scx = 8'hF8; scy = 8'h00; ly = 8'h00; bg_map_sel = 1'b0; bus.fifo_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    observe(8);
    n_tests++; if (obs_ma[1] !== 13'h181F) begin n_fail++; $display("FAIL wrap_col31: got %h required 181f", obs_ma[1]); end
    n_tests++; if (obs_ma[8] !== 13'h1800) begin n_fail++; $display("FAIL wrap_col0: got %h required 1800", obs_ma[8]); end
    n_tests++; if (obs_ma[8] !== bg_map(1)) begin n_fail++; $display("FAIL wrap_model: got %h required %h", obs_ma[8], bg_map(1)); end
    pulse_line_end();
  endtask

  task automatic test_reset_mid();
    bus.fifo_ready = 1'b1;
    win_start = 1'b1; tick(); win_start = 1'b0;
    tick(); tick(); tick(); tick();
    #1;
    n_tests++; if ({bus.vram_rd, win_active} !== 2'b11) begin n_fail++; $display("FAIL pre_reset_hi0: got rd=%b win=%b required 1 1", bus.vram_rd, win_active); end
    reset = 1'b1; tick(); reset = 1'b0;
    #1;
    n_tests++; if (bus.ma_out !== 13'h0) begin n_fail++; $display("FAIL midreset_ma: got %h required 0000", bus.ma_out); end
    n_tests++; if ({bus.vram_rd, bus.push, busy, win_active} !== 4'b0000) begin n_fail++; $display("FAIL midreset_flags: got rd=%b push=%b busy=%b win=%b required 0", bus.vram_rd, bus.push, busy, win_active); end
    n_tests++; if ({bus.pix_hi, bus.pix_lo} !== 16'h0) begin n_fail++; $display("FAIL midreset_pix: got %h%h required 0000", bus.pix_hi, bus.pix_lo); end
  endtask

  task automatic test_priority();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    line_end = 1'b1; win_start = 1'b1; start = 1'b1; tick();
    line_end = 1'b0; win_start = 1'b0; start = 1'b0;
    #1;
    n_tests++; if ({busy, win_active, bus.vram_rd} !== 3'b000) begin n_fail++; $display("FAIL prio_line_end: got busy=%b win=%b rd=%b required 0 0 0", busy, win_active, bus.vram_rd); end
    win_start = 1'b1; start = 1'b1; tick(); win_start = 1'b0; start = 1'b0;
    #1;
    n_tests++; if (win_active !== 1'b1) begin n_fail++; $display("FAIL prio_win_over_start: got %b required 1", win_active); end
    n_tests++; if (bus.ma_out !== win_map(0, 0)) begin n_fail++; $display("FAIL prio_win_map: got %h required %h", bus.ma_out, win_map(0, 0)); end
    tick(); tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    #1;
    n_tests++; if ({busy, win_active, bus.vram_rd} !== 3'b111) begin n_fail++; $display("FAIL restart_flags: got busy=%b win=%b rd=%b required 1 1 1", busy, win_active, bus.vram_rd); end
    n_tests++; if (bus.ma_out !== win_map(0, 0)) begin n_fail++; $display("FAIL restart_map: got %h required %h", bus.ma_out, win_map(0, 0)); end
    pulse_line_end();
  endtask

  task automatic test_random();
    int ntiles, cyc;
    logic [7:0]  idx;
    logic [15:0] exp_pix;
    for (int it = 0; it < 4; it++) begin
      for (int a = 0; a < 8192; a++) vram[a] = 8'($urandom);
      scx = 8'($urandom); scy = 8'($urandom); ly = 8'($urandom);
      bg_map_sel = 1'($urandom); tile_data_sel = 1'($urandom);
      ntiles = 3 + int'($urandom % 4);
      push_log.delete();
      bus.fifo_ready = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      cyc = 0;
      while (push_log.size() < ntiles && cyc < 400) begin
        bus.fifo_ready = 1'($urandom);
        tick();
        cyc++;
      end
      bus.fifo_ready = 1'b0;
      n_tests++; if (push_log.size() < ntiles) begin n_fail++; $display("FAIL rand_timeout it%0d: got %0d pushes required %0d", it, push_log.size(), ntiles); end
      for (int k = 0; k < push_log.size(); k++) begin
        idx = vram[bg_map(k)];
        exp_pix = {vram[exp_tile(idx, tile_data_sel, bg_fy(), 1'b1)],
                   vram[exp_tile(idx, tile_data_sel, bg_fy(), 1'b0)]};
        n_tests++; if (push_log[k] !== exp_pix) begin n_fail++; $display("FAIL rand_pix it%0d t%0d: got %h required %h", it, k, push_log[k], exp_pix); end
      end
      pulse_line_end();
    end
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; start = 1'b0; win_start = 1'b0; line_end = 1'b0;
    bg_map_sel = 1'b0; win_map_sel = 1'b0; tile_data_sel = 1'b0;
    scx = 8'h00; scy = 8'h00; ly = 8'h00; bus.fifo_ready = 1'b0;
    for (int a = 0; a < 8192; a++) vram[a] = 8'h00;
    test_reset();
    test_bg_sequence();
    test_signed_push();
    test_backpressure();
    test_window();
    test_col_wrap();
    test_reset_mid();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
